// File: rtl/wb_sequencer.sv
// Writeback sequencer: arbitrates ALU/LSU results onto the regfile write port, tracks
// outstanding loads and raises operand hazards. Define WB_FORWARD_EN to bypass the
// in-flight write onto op1/op2 instead of stalling decode for one cycle.
module wb_sequencer #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOADS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              ld_issue_valid,
  output logic              ld_issue_ready,
  input  logic [4:0]        ld_issue_rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [DATA_W-1:0] rf_rv1,
  input  logic [DATA_W-1:0] rf_rv2,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int               CNT_W   = $clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]       pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic lsu_fire, alu_fire, issue_fire, sb_set, sb_clr;

  // LSU holds the older instruction, so it always wins and is never back-pressured.
  assign lsu_ready      = 1'b1;
  assign alu_ready      = !lsu_valid;
  assign ld_issue_ready = (count_q < CNT_MAX) &&
                          !((ld_issue_rd != 5'd0) && pending_q[ld_issue_rd]);

  assign lsu_fire   = lsu_valid;
  assign alu_fire   = alu_valid && alu_ready;
  assign issue_fire = ld_issue_valid && ld_issue_ready;
  assign sb_set     = issue_fire && (ld_issue_rd != 5'd0);
  assign sb_clr     = lsu_fire && pending_q[lsu_rd];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (lsu_fire) begin
      rf_we_d    = (lsu_rd != 5'd0);
      rf_rd_d    = lsu_rd;
      rf_wdata_d = lsu_data;
    end else if (alu_fire) begin
      rf_we_d    = (alu_rd != 5'd0);
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end
  end

  // Clear before set: a commit and a re-issue of the same rd leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (sb_clr) pending_d[lsu_rd] = 1'b0;
    if (sb_set) pending_d[ld_issue_rd] = 1'b1;
    case ({sb_set, sb_clr})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments; the scoreboard is plain flops, so it is
    // reset along with the rest and loads in flight at reset are forgotten.
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
      count_q    <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_FORWARD_EN
  logic fwd1, fwd2;
  assign fwd1     = rf_we_q && (rf_rd_q == rs1) && (rs1 != 5'd0);
  assign fwd2     = rf_we_q && (rf_rd_q == rs2) && (rs2 != 5'd0);
  assign op1      = fwd1 ? rf_wdata_q : rf_rv1;
  assign op2      = fwd2 ? rf_wdata_q : rf_rv2;
  assign rs1_busy = (rs1 != 5'd0) && pending_q[rs1];
  assign rs2_busy = (rs2 != 5'd0) && pending_q[rs2];
`else
  // The in-flight write lands at the end of this cycle, so the regfile read is stale.
  assign op1      = rf_rv1;
  assign op2      = rf_rv2;
  assign rs1_busy = (rs1 != 5'd0) && (pending_q[rs1] || (rf_we_q && (rf_rd_q == rs1)));
  assign rs2_busy = (rs2 != 5'd0) && (pending_q[rs2] || (rf_we_q && (rf_rd_q == rs2)));
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: a queue-based model of outstanding loads and the
// last committed write is compared against the DUT every negedge, plus literal checks.
module tb_wb_sequencer;
  localparam int DATA_W    = 32;
  localparam int MAX_LOADS = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic              ld_issue_valid, ld_issue_ready;
  logic [4:0]        alu_rd, lsu_rd, ld_issue_rd, rs1, rs2, rf_rd;
  logic [DATA_W-1:0] alu_data, lsu_data, rf_rv1, rf_rv2, op1, op2, rf_wdata;
  logic              rs1_busy, rs2_busy, rf_we;

  wb_sequencer #(.DATA_W(DATA_W), .MAX_LOADS(MAX_LOADS)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
    .rs1(rs1), .rs2(rs2), .rf_rv1(rf_rv1), .rf_rv2(rf_rv2), .op1(op1), .op2(op2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding loads as a list of destination registers, plus the last write.
  int                out_q[$];
  bit                m_we    = 1'b0;
  int                m_rd    = 0;
  logic [DATA_W-1:0] m_wdata = '0;

  function automatic bit is_pending(input int r);
    foreach (out_q[i]) if (out_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_issue_ready();
    return (out_q.size() < MAX_LOADS) && !(ld_issue_rd != 0 && is_pending(int'(ld_issue_rd)));
  endfunction

  function automatic bit exp_busy(input int r);
    return (r != 0) && (is_pending(r) || (!FWD && m_we && m_rd == r));
  endfunction

  function automatic logic [DATA_W-1:0] exp_op(input int r, input logic [DATA_W-1:0] rv);
    return (FWD && m_we && m_rd == r && r != 0) ? m_wdata : rv;
  endfunction

  initial forever begin
    bit iss;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      out_q.delete();
      m_we    = 1'b0;
      m_rd    = 0;
      m_wdata = '0;
    end else begin
      iss = ld_issue_valid && exp_issue_ready();
      if (lsu_valid) begin
        m_we    = (lsu_rd != 0);
        m_rd    = int'(lsu_rd);
        m_wdata = lsu_data;
        for (int i = 0; i < out_q.size(); i++)
          if (out_q[i] == int'(lsu_rd)) begin
            out_q.delete(i);
            break;
          end
      end else if (alu_valid) begin
        m_we    = (alu_rd != 0);
        m_rd    = int'(alu_rd);
        m_wdata = alu_data;
      end else begin
        m_we = 1'b0;
      end
      if (iss && ld_issue_rd != 0) out_q.push_back(int'(ld_issue_rd));
    end
  end

  always @(negedge clk) begin
    check("m_alu_ready", 64'(alu_ready), 64'(!lsu_valid));
    check("m_lsu_ready", 64'(lsu_ready), 64'(1'b1));
    check("m_issue_ready", 64'(ld_issue_ready), 64'(exp_issue_ready()));
    check("m_rf_we", 64'(rf_we), 64'(m_we));
    check("m_rf_rd", 64'(rf_rd), 64'(m_rd));
    check("m_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    check("m_rs1_busy", 64'(rs1_busy), 64'(exp_busy(int'(rs1))));
    check("m_rs2_busy", 64'(rs2_busy), 64'(exp_busy(int'(rs2))));
    check("m_op1", 64'(op1), 64'(exp_op(int'(rs1), rf_rv1)));
    check("m_op2", 64'(op2), 64'(exp_op(int'(rs2), rf_rv2)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ld_a[4] = '{1, 3, 4, 6};
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
    ld_issue_valid = 0; ld_issue_rd = 0;
    rs1 = 0; rs2 = 0; rf_rv1 = '0; rf_rv2 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_we", 64'(rf_we), 64'(0));
    check("rst_rd", 64'(rf_rd), 64'(0));
    check("rst_wdata", 64'(rf_wdata), 64'(0));
    #9 rst_n = 1'b1;
    tick();

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 check("alu_ready_idle", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 0;
    #1;
    check("alu_we", 64'(rf_we), 64'(1));
    check("alu_rd", 64'(rf_rd), 64'(5));
    check("alu_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
    tick();
    check("alu_we_drop", 64'(rf_we), 64'(0));
    check("alu_rd_hold", 64'(rf_rd), 64'(5));

    // Simultaneous ALU and LSU: LSU first
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
    #1 check("arb_alu_stall", 64'(alu_ready), 64'(0));
    tick();
    lsu_valid = 0;
    #1;
    check("arb_lsu_rd", 64'(rf_rd), 64'(4));
    check("arb_lsu_data", 64'(rf_wdata), 64'(32'h22));
    tick();
    alu_valid = 0;
    #1;
    check("arb_alu_rd", 64'(rf_rd), 64'(3));
    check("arb_alu_data", 64'(rf_wdata), 64'(32'h11));
    tick();

    // Fill the scoreboard
    for (int r = 1; r <= 4; r++) begin
      ld_issue_valid = 1; ld_issue_rd = 5'(r);
      #1 check("fill_ready", 64'(ld_issue_ready), 64'(1));
      tick();
    end
    ld_issue_rd = 6; rs1 = 2; rs2 = 0;
    #1;
    check("full_block", 64'(ld_issue_ready), 64'(0));
    check("rs1_pending", 64'(rs1_busy), 64'(1));
    check("rs0_never", 64'(rs2_busy), 64'(0));
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h2222;
    tick();
    lsu_valid = 0;
    #1;
    check("ready_after_commit", 64'(ld_issue_ready), 64'(1));
`ifdef WB_FORWARD_EN
    check("commit_fwd_busy", 64'(rs1_busy), 64'(0));
    check("commit_fwd_op1", 64'(op1), 64'(32'h2222));
`else
    check("commit_raw_busy", 64'(rs1_busy), 64'(1));
    check("commit_raw_op1", 64'(op1), 64'(0));
`endif
    tick();
    ld_issue_valid = 0;
    #1 check("rs1_clear", 64'(rs1_busy), 64'(0));
    rs1 = 0;
    foreach (ld_a[i]) begin
      lsu_valid = 1; lsu_rd = 5'(ld_a[i]); lsu_data = DATA_W'(32'h100 + ld_a[i]);
      tick();
    end
    lsu_valid = 0;

    // ALU write to x0, then WAW stall on a repeated load destination
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    #1 check("x0_ready", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 0;
    #1 check("x0_no_we", 64'(rf_we), 64'(0));
    ld_issue_valid = 1; ld_issue_rd = 7;
    #1 check("ld7_first", 64'(ld_issue_ready), 64'(1));
    tick();
    #1 check("ld7_waw", 64'(ld_issue_ready), 64'(0));
    tick();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    #1 check("ld7_waw_commit_cycle", 64'(ld_issue_ready), 64'(0));
    tick();
    lsu_valid = 0;
    #1 check("ld7_second", 64'(ld_issue_ready), 64'(1));
    tick();
    ld_issue_valid = 0; rs1 = 7;
    #1 check("ld7_busy", 64'(rs1_busy), 64'(1));
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h78;
    tick();
    lsu_valid = 0; rs1 = 0;
    tick();

    // RAW against the in-flight write
    alu_valid = 1; alu_rd = 9; alu_data = 32'hA5A5A5A5;
    tick();
    alu_valid = 0; rs1 = 9; rf_rv1 = '0; rs2 = 9; rf_rv2 = 32'h5A5A5A5A;
    #1;
`ifdef WB_FORWARD_EN
    check("raw_op1", 64'(op1), 64'(32'hA5A5A5A5));
    check("raw_busy", 64'(rs1_busy), 64'(0));
`else
    check("raw_op1", 64'(op1), 64'(0));
    check("raw_busy", 64'(rs1_busy), 64'(1));
`endif
    tick();
    rs1 = 0; rs2 = 0; rf_rv2 = '0;

    // Mid-cycle reset with loads pending and a write in flight
    ld_issue_valid = 1; ld_issue_rd = 1;
    tick();
    ld_issue_rd = 2; alu_valid = 1; alu_rd = 10; alu_data = 32'hAA;
    tick();
    ld_issue_valid = 0; alu_valid = 0; rs1 = 1; rs2 = 2;
    #1;
    check("pre_rst_busy1", 64'(rs1_busy), 64'(1));
    check("pre_rst_busy2", 64'(rs2_busy), 64'(1));
    check("pre_rst_we", 64'(rf_we), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async_we", 64'(rf_we), 64'(0));
    check("rst_async_rd", 64'(rf_rd), 64'(0));
    check("rst_async_busy1", 64'(rs1_busy), 64'(0));
    check("rst_async_busy2", 64'(rs2_busy), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    ld_issue_valid = 1; ld_issue_rd = 1;
    #1 check("post_rst_issue", 64'(ld_issue_ready), 64'(1));
    tick();
    for (int r = 2; r <= 4; r++) begin
      ld_issue_rd = 5'(r);
      #1 check("post_rst_fill", 64'(ld_issue_ready), 64'(1));
      tick();
    end
    ld_issue_rd = 5;
    #1 check("post_rst_full", 64'(ld_issue_ready), 64'(0));
    ld_issue_valid = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Writeback-side driver of the register file write port (rd/we/wdata).
- Accepts completed results from the single-cycle ALU path and the multi-cycle load/store unit, arbitrates between them, and registers one write per cycle into the regfile.
- Keeps a pending-load scoreboard and produces busy flags for decode stall logic.
- Optionally forwards the in-flight write onto the operand read path.

Parameters:
- DATA_W, 32, result/operand width
- MAX_LOADS, 4, maximum outstanding loads (1..31)

Ports:
- clk  in  1  clock; all state changes at posedge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  load data available
- lsu_ready  out  1  load data accepted
- lsu_rd  in  5  load destination register
- lsu_data  in  DATA_W  load data
- ld_issue_valid  in  1  decode issuing a load
- ld_issue_ready  out  1  load issue permitted
- ld_issue_rd  in  5  issuing load's destination
- rs1  in  5  decode source 1 address
- rs2  in  5  decode source 2 address
- rf_rv1  in  DATA_W  regfile read value 1
- rf_rv2  in  DATA_W  regfile read value 2
- op1  out  DATA_W  operand 1 to execute
- op2  out  DATA_W  operand 2 to execute
- rs1_busy  out  1  rs1 not yet readable; decode must stall
- rs2_busy  out  1  rs2 not yet readable; decode must stall
- rf_we  out  1  regfile write enable
- rf_rd  out  5  regfile write address
- rf_wdata  out  DATA_W  regfile write data

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_rd=0, rf_wdata=0, pending[31:0]=0, load count=0.
  - Loads in flight at reset are discarded.
  - Outputs take reset values immediately, not at the next edge.
- Handshake: a transfer occurs when valid && ready at posedge.
  - Producers hold valid/rd/data stable until the transfer.
- Arbitration: LSU has priority (older instruction).
  - lsu_ready=1 at all times.
  - alu_ready = !lsu_valid (combinational).
- Output stage: one register, latency 1.
  - Cycle after a transfer: rf_rd/rf_wdata = winner's rd/data; rf_we = (rd != 0).
  - No transfer: rf_we=0; rf_rd/rf_wdata hold their previous values.
  - x0 is never written. The transfer is still consumed.
- Scoreboard:
  - Load issue (ld_issue_valid && ld_issue_ready) with ld_issue_rd != 0: sets pending[rd], count+1.
  - ld_issue_ready = (count < MAX_LOADS) && !(ld_issue_rd != 0 && pending[ld_issue_rd]), which stalls WAW on the same rd.
  - Issue to x0: accepted, no state change.
  - LSU transfer with pending[lsu_rd]=1: clears the bit, count-1.
  - LSU transfer with the bit clear (protocol error): the write still happens; pending and count are unchanged.
  - Same-cycle issue and LSU commit, different rd: set and clear both apply; count unchanged.
  - Same rd in both: clear then set, so the bit ends set and count is unchanged. This is only legal once the stall has dropped.
- Busy: rsN_busy = (rsN != 0) && (pending[rsN] || raw_inflight(rsN)).
  - raw_inflight(r) = rf_we && rf_rd == r (the write lands at the end of this cycle, so the regfile still returns the old value).
  - With forwarding enabled, raw_inflight is forced to 0.
- Operands: opN = rf_rvN unless forwarded (see below).
- Widths: count is the minimum width for 0..MAX_LOADS and never wraps. Issue is blocked at MAX_LOADS; a decrement happens only when the pending bit is set.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: opN = rf_wdata when rf_we && rf_rd == rsN && rsN != 0, else rf_rvN. raw_inflight contributes nothing to busy, which removes the 1-cycle RAW stall.
- Undefined: opN = rf_rvN (pure pass-through). Busy includes raw_inflight, so decode stalls one cycle on a RAW against the in-flight write.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- ALU alu_valid=1, rd=5, data=0xDEADBEEF, lsu idle → alu_ready=1; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- ALU (rd=3, 0x11) and LSU (rd=4, 0x22) both valid:
  - Cycle 1: alu_ready=0; write 4/0x22.
  - Cycle 2: write 3/0x11.
- Issue loads to rd 1, 2, 3, 4 (MAX_LOADS=4) → ld_issue_ready=0 for rd 6. Then:
  - LSU commits rd=2 → ready returns next cycle.
  - rs1=2 busy until that commit; rs1=0 never busy.
- ALU result rd=0, data=0x55 → alu_ready=1, rf_we stays 0. Issue a load to rd 7 twice → second issue blocked until lsu_rd=7 commits.
- Write rd=9 with 0xA5A5A5A5 in flight, rs1=9, rf_rv1=0:
  - WB_FORWARD_EN defined: op1=0xA5A5A5A5, rs1_busy=0.
  - WB_FORWARD_EN undefined: op1=0, rs1_busy=1 for that cycle.
- Loads pending on rd 1, 2; assert rst_n=0 mid-cycle → rf_we=0 and busy flags low immediately. After release, issue to rd 1 is accepted; count restarts at 0.
